// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: load/store opcodes,
// RMW state encoding, RAM control polarities and opcode classification helpers.
package mem_access_unit_pkg;

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2
    } rmw_state_e;

    function automatic logic is_load_op(input logic [7:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] a);
        return ((op inside {OP_LH, OP_LHU, OP_SH}) && a[0]) ||
               ((op inside {OP_LW, OP_SW}) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// RAM-side bus of the load/store unit: the unit is master, the word-only RAM is slave.
interface mem_access_unit_if #(parameter int ADDR_W = 17);
    logic              ram_ce_o;
    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [31:0]       ram_data_o;
    logic [31:0]       ram_data_i;

    modport master (output ram_ce_o, ram_we_o, ram_addr_o, ram_data_o, input ram_data_i);
    modport slave  (input ram_ce_o, ram_we_o, ram_addr_o, ram_data_o, output ram_data_i);
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Big-endian byte/halfword lane handling: load select/extend and store lane merge.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [7:0]  aluop_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] word_i,
    input  logic [31:0] store_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);
    logic [7:0]  byte_lane [4];
    logic [15:0] half_lane [2];
    logic [31:0] byte_merge;
    logic [31:0] half_merge;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane 0 is the most significant byte/halfword of the word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign byte_lane[gi] = word_i[31-8*gi -: 8];
        assign byte_merge[31-8*gi -: 8] = (addr_i == 2'(gi)) ? store_i[7:0] : word_i[31-8*gi -: 8];
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_half
        assign half_lane[gi] = word_i[31-16*gi -: 16];
        assign half_merge[31-16*gi -: 16] = (addr_i[1] == 1'(gi)) ? store_i[15:0] : word_i[31-16*gi -: 16];
    end

    assign sel_byte = byte_lane[addr_i];
    assign sel_half = half_lane[addr_i[1]];

    always_comb begin
        load_o = word_i;
        case (aluop_i)
            OP_LB:   load_o = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_o = {24'd0, sel_byte};
            OP_LH:   load_o = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  load_o = {16'd0, sel_half};
            default: load_o = word_i;
        endcase
    end

    always_comb begin
        merge_o = store_i;
        case (aluop_i)
            OP_SB:   merge_o = byte_merge;
            OP_SH:   merge_o = half_merge;
            default: merge_o = store_i;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-only RAM; SB/SH are done as a
// stalling read-modify-write because the RAM has no byte enables.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic        stall_i,
    input  logic        flush_i,
    mem_access_unit_if.master ram_bus,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic        misalign_o
);
    rmw_state_e  state_q, state_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] load_word, merge_word;
    logic        is_load, is_store, is_rmw, bad_align;
    logic [ADDR_W-1:0] word_addr;
    logic        addr_unused;

    assign is_load   = is_load_op(aluop_i);
    assign is_store  = is_store_op(aluop_i);
    assign is_rmw    = (aluop_i == OP_SB) || (aluop_i == OP_SH);
    assign bad_align = is_misaligned(aluop_i, mem_addr_i[1:0]);
    assign word_addr = mem_addr_i[ADDR_W+1:2];
    assign addr_unused = ^mem_addr_i[31:ADDR_W+2];

    mem_lane_align u_lane_align (
        .aluop_i (aluop_i),
        .addr_i  (mem_addr_i[1:0]),
        .word_i  (ram_bus.ram_data_i),
        .store_i (reg2_i),
        .load_o  (load_word),
        .merge_o (merge_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
        end
    end

    // HOLD keeps a still-stalled store from starting a second RMW.
    always_comb begin
        state_d = state_q;
        merge_d = merge_q;
        case (state_q)
            ST_IDLE: begin
                if (is_rmw && !bad_align) begin
                    state_d = ST_WRITE;
                    merge_d = merge_word;
                end
            end
            ST_WRITE: state_d = stall_i ? ST_HOLD : ST_IDLE;
            ST_HOLD:  if (!stall_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (flush_i) state_d = ST_IDLE;
    end

    always_comb begin
        ram_bus.ram_ce_o   = CHIP_DISABLE;
        ram_bus.ram_we_o   = WRITE_DISABLE;
        ram_bus.ram_addr_o = '0;
        ram_bus.ram_data_o = '0;
        wd_o       = '0;
        wreg_o     = 1'b0;
        wdata_o    = '0;
        stallreq_o = 1'b0;
        misalign_o = 1'b0;
        if (rst) begin
            wd_o    = wd_i;
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
            if (bad_align) begin
                misalign_o = 1'b1;
                wreg_o     = 1'b0;
            end else if (is_load) begin
                ram_bus.ram_ce_o   = CHIP_ENABLE;
                ram_bus.ram_addr_o = word_addr;
                wdata_o            = load_word;
            end else if (is_store && !is_rmw) begin
                ram_bus.ram_ce_o   = CHIP_ENABLE;
                ram_bus.ram_we_o   = WRITE_ENABLE;
                ram_bus.ram_addr_o = word_addr;
                ram_bus.ram_data_o = reg2_i;
            end else if (is_rmw) begin
                case (state_q)
                    ST_IDLE: begin
                        ram_bus.ram_ce_o   = CHIP_ENABLE;
                        ram_bus.ram_addr_o = word_addr;
                        stallreq_o         = !flush_i;
                    end
                    ST_WRITE: begin
                        ram_bus.ram_ce_o   = CHIP_ENABLE;
                        ram_bus.ram_we_o   = flush_i ? WRITE_DISABLE : WRITE_ENABLE;
                        ram_bus.ram_addr_o = word_addr;
                        ram_bus.ram_data_o = merge_q;
                    end
                    default: ;
                endcase
            end
            if (is_store) wreg_o = 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised self-checking bench for mem_access_unit against a word-array RAM
// and an arithmetic reference model of lane select, extension and merge.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int ADDR_W = 17;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  aluop    = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] reg2     = '0;
    logic [4:0]  wd       = '0;
    logic        wreg     = 1'b0;
    logic [31:0] wdata    = '0;
    logic        stall    = 1'b0;
    logic        flush    = 1'b0;
    logic [4:0]  wd_o;
    logic        wreg_o, stallreq_o, misalign_o;
    logic [31:0] wdata_o;

    mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop),
        .mem_addr_i (mem_addr),
        .reg2_i     (reg2),
        .wd_i       (wd),
        .wreg_i     (wreg),
        .wdata_i    (wdata),
        .stall_i    (stall),
        .flush_i    (flush),
        .ram_bus    (bus),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .stallreq_o (stallreq_o),
        .misalign_o (misalign_o)
    );

    // Word-only RAM with combinational read; counts write pulses.
    logic [31:0] ram [64];
    logic [31:0] ref_mem [64];
    int wr_cnt = 0;
    assign bus.ram_data_i = ram[bus.ram_addr_o[5:0]];
    always @(posedge clk) begin
        if (bus.ram_ce_o && bus.ram_we_o) begin
            ram[bus.ram_addr_o[5:0]] <= bus.ram_data_o;
            wr_cnt <= wr_cnt + 1;
        end
    end

    int chk_cnt  = 0;
    int pass_cnt = 0;

    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * (3 - int'(a)))) & 32'hFF;
        h = (w >> (16 * (1 - int'(a[1])))) & 32'hFFFF;
        if (op == OP_LB)  return (b >= 32'h80)   ? (b | 32'hFFFFFF00) : b;
        if (op == OP_LBU) return b;
        if (op == OP_LH)  return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
        if (op == OP_LHU) return h;
        return w;
    endfunction

    function automatic logic [31:0] m_merge(input logic [7:0] op, input logic [1:0] a,
                                            input logic [31:0] old, input logic [31:0] d);
        int sh;
        if (op == OP_SB) begin
            sh = 8 * (3 - int'(a));
            return (old & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
        end
        sh = 16 * (1 - int'(a[1]));
        return (old & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
    endfunction

    function automatic logic [31:0] gen_addr(input logic [7:0] op);
        logic [31:0] a;
        a = 32'($urandom_range(0, 63)) << 2;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) a = a + 32'(2 * $urandom_range(0, 1));
        else if (op == OP_LB || op == OP_LBU || op == OP_SB) a = a + 32'($urandom_range(0, 3));
        return a;
    endfunction

    task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
        aluop = op; mem_addr = a; reg2 = d;
    endtask

    task automatic test_reset();
        drive(OP_SW, 32'h10, 32'hCAFEF00D);
        wd = 5'd7; wreg = 1'b1; wdata = 32'h12345678;
        #1;
        chk_cnt++;
        if ({bus.ram_ce_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_data_o, wd_o, wreg_o, wdata_o, stallreq_o, misalign_o} !== '0)
            $display("FAIL reset_outputs: ce=%b we=%b wreg=%b wdata=%h stallreq=%b required all zero",
                     bus.ram_ce_o, bus.ram_we_o, wreg_o, wdata_o, stallreq_o);
        else pass_cnt++;
        drive(8'h21, 32'h0, 32'h0);
        @(negedge clk); rst = 1'b1;
        #1;
        chk_cnt++;
        if ({wd_o, wreg_o, wdata_o} !== {5'd7, 1'b1, 32'h12345678} || bus.ram_ce_o !== 1'b0)
            $display("FAIL post_reset_nonmem: wd=%0d wreg=%b wdata=%h ce=%b required 7 1 12345678 0", wd_o, wreg_o, wdata_o, bus.ram_ce_o);
        else pass_cnt++;
        $display("txn reset release");
        @(posedge clk); #1;
    endtask

    task automatic test_nonmem();
        for (int i = 0; i < 6; i++) begin
            drive(8'($urandom_range(0, 8'hDF)), $urandom, $urandom);
            wd = 5'($urandom); wreg = 1'($urandom); wdata = $urandom;
            #1;
            chk_cnt++;
            if ({wd_o, wreg_o, wdata_o} !== {wd, wreg, wdata} ||
                {bus.ram_ce_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_data_o, stallreq_o, misalign_o} !== '0)
                $display("FAIL nonmem_pass: wd=%0d wreg=%b wdata=%h ce=%b addr=%h required %0d %b %h 0 0",
                         wd_o, wreg_o, wdata_o, bus.ram_ce_o, bus.ram_addr_o, wd, wreg, wdata);
            else pass_cnt++;
            $display("txn nonmem op=%h wdata=%h", aluop, wdata);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_ext();
        logic [7:0]  ops  [4] = '{OP_LB, OP_LBU, OP_LH, OP_LW};
        logic [31:0] adrs [4] = '{32'h16, 32'h16, 32'h14, 32'h14};
        logic [31:0] exps [4] = '{32'hFFFFFFF2, 32'h000000F2, 32'hFFFF8071, 32'h8071F2A4};
        ram[5] <= 32'h8071_F2A4; ref_mem[5] = 32'h8071_F2A4;
        wreg = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], adrs[i], 32'h0);
            #1;
            chk_cnt++;
            if (wdata_o !== exps[i] || {bus.ram_ce_o, bus.ram_we_o, wreg_o, misalign_o, stallreq_o} !== 5'b10100)
                $display("FAIL load_ext_%0d: wdata=%h ce=%b we=%b wreg=%b required %h 1 0 1",
                         i, wdata_o, bus.ram_ce_o, bus.ram_we_o, wreg_o, exps[i]);
            else pass_cnt++;
            $display("txn load op=%h addr=%h wdata=%h", aluop, mem_addr, wdata_o);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random_loads();
        logic [7:0] ops [5] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
        logic [31:0] exp_w;
        int idx;
        for (int i = 0; i < 24; i++) begin
            drive(ops[$urandom_range(0, 4)], 32'h0, $urandom);
            mem_addr = gen_addr(aluop);
            idx = int'(mem_addr[7:2]);
            exp_w = m_load(aluop, mem_addr[1:0], ref_mem[idx]);
            #1;
            chk_cnt++;
            if (wdata_o !== exp_w || bus.ram_addr_o !== ADDR_W'(idx) || misalign_o !== 1'b0)
                $display("FAIL rand_load: op=%h addr=%h wdata=%h ram_addr=%h required %h %h",
                         aluop, mem_addr, wdata_o, bus.ram_addr_o, exp_w, idx);
            else pass_cnt++;
            $display("txn load op=%h addr=%h wdata=%h", aluop, mem_addr, wdata_o);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sb_rmw();
        int w0;
        ram[2] <= 32'h11223344; ref_mem[2] = 32'h11223344;
        w0 = wr_cnt;
        drive(OP_SB, 32'h09, 32'hAB);
        #1;
        chk_cnt++;
        if ({stallreq_o, bus.ram_we_o, bus.ram_ce_o} !== 3'b101)
            $display("FAIL sb_cycle1: stallreq=%b we=%b ce=%b required 1 0 1", stallreq_o, bus.ram_we_o, bus.ram_ce_o);
        else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if ({stallreq_o, bus.ram_we_o, bus.ram_ce_o} !== 3'b011 || bus.ram_data_o !== 32'h11AB3344)
            $display("FAIL sb_cycle2: stallreq=%b we=%b data=%h required 0 1 11ab3344", stallreq_o, bus.ram_we_o, bus.ram_data_o);
        else pass_cnt++;
        @(posedge clk); #1;
        drive(8'h00, 32'h0, 32'h0);
        ref_mem[2] = 32'h11AB3344;
        chk_cnt++;
        if (ram[2] !== 32'h11AB3344 || wr_cnt - w0 !== 1)
            $display("FAIL sb_result: word=%h writes=%0d required 11ab3344 1", ram[2], wr_cnt - w0);
        else pass_cnt++;
        $display("txn sb addr=09 data=ab word=%h", ram[2]);
    endtask

    task automatic do_rmw(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d, input int nhold);
        int w0, idx;
        logic [31:0] exp_w;
        idx = int'(a[7:2]);
        exp_w = m_merge(op, a[1:0], ref_mem[idx], d);
        w0 = wr_cnt;
        drive(op, a, d); stall = 1'b0; wreg = 1'b1;
        #1;
        chk_cnt++;
        if ({stallreq_o, bus.ram_we_o, bus.ram_ce_o, wreg_o} !== 4'b1010 || bus.ram_addr_o !== ADDR_W'(idx))
            $display("FAIL rmw_read: stallreq=%b we=%b ce=%b wreg=%b addr=%h required 1 0 1 0 %h",
                     stallreq_o, bus.ram_we_o, bus.ram_ce_o, wreg_o, bus.ram_addr_o, idx);
        else pass_cnt++;
        @(posedge clk); #1;
        stall = (nhold > 0);
        #1;
        chk_cnt++;
        if ({stallreq_o, bus.ram_we_o, bus.ram_ce_o} !== 3'b011 || bus.ram_data_o !== exp_w)
            $display("FAIL rmw_write: stallreq=%b we=%b data=%h required 0 1 %h", stallreq_o, bus.ram_we_o, bus.ram_data_o, exp_w);
        else pass_cnt++;
        @(posedge clk); #1;
        for (int i = 0; i < nhold; i++) begin
            stall = (i < nhold - 1);
            #1;
            chk_cnt++;
            if ({bus.ram_ce_o, bus.ram_we_o, stallreq_o} !== 3'b000)
                $display("FAIL rmw_hold_%0d: ce=%b we=%b stallreq=%b required 0 0 0", i, bus.ram_ce_o, bus.ram_we_o, stallreq_o);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        drive(8'h00, 32'h0, 32'h0); stall = 1'b0;
        ref_mem[idx] = exp_w;
        chk_cnt++;
        if (ram[idx] !== exp_w || wr_cnt - w0 !== 1)
            $display("FAIL rmw_result: word=%h writes=%0d required %h 1", ram[idx], wr_cnt - w0, exp_w);
        else pass_cnt++;
        $display("txn rmw op=%h addr=%h data=%h hold=%0d word=%h", op, a, d, nhold, ram[idx]);
    endtask

    task automatic test_rmw_stall();
        do_rmw(OP_SH, 32'h22, 32'h0000BEEF, 3);
        for (int i = 0; i < 8; i++) begin
            aluop = ($urandom_range(0, 1) != 0) ? OP_SB : OP_SH;
            do_rmw(aluop, gen_addr(aluop), $urandom, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_misaligned();
        logic [7:0] ops [5] = '{OP_LH, OP_LHU, OP_SH, OP_LW, OP_SW};
        int w0;
        wreg = 1'b1;
        drive(OP_LW, 32'h06, 32'h0);
        #1;
        chk_cnt++;
        if ({misalign_o, wreg_o, bus.ram_ce_o} !== 3'b100)
            $display("FAIL misalign_lw: misalign=%b wreg=%b ce=%b required 1 0 0", misalign_o, wreg_o, bus.ram_ce_o);
        else pass_cnt++;
        @(posedge clk); #1;
        w0 = wr_cnt;
        drive(OP_SH, 32'h03, 32'h5A5A);
        #1;
        chk_cnt++;
        if ({misalign_o, bus.ram_ce_o, bus.ram_we_o, stallreq_o} !== 4'b1000)
            $display("FAIL misalign_sh: misalign=%b ce=%b we=%b stallreq=%b required 1 0 0 0",
                     misalign_o, bus.ram_ce_o, bus.ram_we_o, stallreq_o);
        else pass_cnt++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_cnt++;
        if (ram[0] !== ref_mem[0] || wr_cnt !== w0 || stallreq_o !== 1'b0)
            $display("FAIL misalign_sh_ram: word=%h writes=%0d stallreq=%b required %h 0 0", ram[0], wr_cnt - w0, stallreq_o, ref_mem[0]);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            aluop = ops[$urandom_range(0, 4)];
            mem_addr = 32'($urandom_range(0, 63)) << 2;
            if (aluop == OP_LW || aluop == OP_SW) mem_addr = mem_addr + 32'($urandom_range(1, 3));
            else mem_addr = mem_addr + 32'(1 + 2 * $urandom_range(0, 1));
            #1;
            chk_cnt++;
            if ({misalign_o, wreg_o, bus.ram_ce_o, bus.ram_we_o} !== 4'b1000)
                $display("FAIL misalign_rand: op=%h addr=%h misalign=%b wreg=%b ce=%b required 1 0 0",
                         aluop, mem_addr, misalign_o, wreg_o, bus.ram_ce_o);
            else pass_cnt++;
            $display("txn misaligned op=%h addr=%h", aluop, mem_addr);
            @(posedge clk); #1;
        end
        drive(8'h00, 32'h0, 32'h0);
    endtask

    task automatic test_sw();
        drive(OP_SW, 32'h10, 32'hDEADBEEF); wreg = 1'b1;
        #1;
        chk_cnt++;
        if ({bus.ram_ce_o, bus.ram_we_o, stallreq_o, wreg_o, misalign_o} !== 5'b11000 ||
            bus.ram_addr_o !== ADDR_W'(4) || bus.ram_data_o !== 32'hDEADBEEF)
            $display("FAIL sw: ce=%b we=%b stallreq=%b addr=%h data=%h required 1 1 0 4 deadbeef",
                     bus.ram_ce_o, bus.ram_we_o, stallreq_o, bus.ram_addr_o, bus.ram_data_o);
        else pass_cnt++;
        @(posedge clk); #1;
        drive(8'h00, 32'h0, 32'h0);
        ref_mem[4] = 32'hDEADBEEF;
        chk_cnt++;
        if (ram[4] !== 32'hDEADBEEF)
            $display("FAIL sw_result: word=%h required deadbeef", ram[4]);
        else pass_cnt++;
        $display("txn sw addr=10 data=deadbeef");
    endtask

    task automatic test_cancel();
        int w0;
        w0 = wr_cnt;
        drive(OP_SB, 32'h0D, 32'h77); flush = 1'b1;
        #1;
        chk_cnt++;
        if (stallreq_o !== 1'b0)
            $display("FAIL flush_idle_stallreq: stallreq=%b required 0", stallreq_o);
        else pass_cnt++;
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        chk_cnt++;
        if ({stallreq_o, bus.ram_we_o} !== 2'b10)
            $display("FAIL flush_idle_stays: stallreq=%b we=%b required 1 0", stallreq_o, bus.ram_we_o);
        else pass_cnt++;
        @(posedge clk); #1;
        flush = 1'b1;
        #1;
        chk_cnt++;
        if (bus.ram_we_o !== 1'b0)
            $display("FAIL flush_write_cancel: we=%b required 0", bus.ram_we_o);
        else pass_cnt++;
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        chk_cnt++;
        if ({stallreq_o, bus.ram_we_o} !== 2'b10 || ram[3] !== ref_mem[3] || wr_cnt !== w0)
            $display("FAIL flush_result: stallreq=%b we=%b word=%h writes=%0d required 1 0 %h 0",
                     stallreq_o, bus.ram_we_o, ram[3], wr_cnt - w0, ref_mem[3]);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk_cnt++;
        if ({bus.ram_ce_o, bus.ram_we_o, bus.ram_data_o, wreg_o, wdata_o, stallreq_o, misalign_o} !== '0)
            $display("FAIL reset_in_write: ce=%b we=%b data=%h stallreq=%b required all zero",
                     bus.ram_ce_o, bus.ram_we_o, bus.ram_data_o, stallreq_o);
        else pass_cnt++;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b1;
        #1;
        chk_cnt++;
        if ({stallreq_o, bus.ram_we_o} !== 2'b10 || ram[3] !== ref_mem[3] || wr_cnt !== w0)
            $display("FAIL reset_result: stallreq=%b we=%b word=%h writes=%0d required 1 0 %h 0",
                     stallreq_o, bus.ram_we_o, ram[3], wr_cnt - w0, ref_mem[3]);
        else pass_cnt++;
        drive(8'h00, 32'h0, 32'h0);
        $display("txn cancelled sb addr=0d");
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] ops [5] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
        logic [31:0] exp_w;
        int idx, kind;
        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(0, 3));
            wreg = 1'b1; wdata = $urandom; wd = 5'($urandom);
            if (kind == 3) begin
                aluop = ($urandom_range(0, 1) != 0) ? OP_SB : OP_SH;
                do_rmw(aluop, gen_addr(aluop), $urandom, int'($urandom_range(0, 2)));
            end else begin
                aluop = (kind == 0) ? 8'h11 : (kind == 1) ? ops[$urandom_range(0, 4)] : OP_SW;
                mem_addr = gen_addr(aluop); reg2 = $urandom;
                idx = int'(mem_addr[7:2]);
                exp_w = (kind == 1) ? m_load(aluop, mem_addr[1:0], ref_mem[idx]) : wdata;
                #1;
                chk_cnt++;
                if (wdata_o !== exp_w || wreg_o !== (kind != 2) || bus.ram_we_o !== (kind == 2) ||
                    bus.ram_ce_o !== (kind != 0) || stallreq_o !== 1'b0)
                    $display("FAIL b2b: op=%h addr=%h wdata=%h wreg=%b ce=%b we=%b required %h %b %b %b",
                             aluop, mem_addr, wdata_o, wreg_o, bus.ram_ce_o, bus.ram_we_o,
                             exp_w, kind != 2, kind != 0, kind == 2);
                else pass_cnt++;
                if (kind == 2) ref_mem[idx] = reg2;
                $display("txn b2b op=%h addr=%h wdata=%h", aluop, mem_addr, wdata_o);
                @(posedge clk); #1;
            end
        end
        drive(8'h00, 32'h0, 32'h0);
        #1;
        for (int i = 0; i < 64; i++) begin
            chk_cnt++;
            if (ram[i] !== ref_mem[i])
                $display("FAIL ram_final_%0d: word=%h required %h", i, ram[i], ref_mem[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = $urandom;
            ram[i] <= ref_mem[i];
        end
        test_reset();
        test_nonmem();
        test_load_ext();
        test_random_loads();
        test_sb_rmw();
        test_rmw_stall();
        test_misaligned();
        test_sw();
        test_cancel();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit directly upstream of the 32-bit word-only data RAM.
- Turns the EX/MEM load/store op, byte address and store data into RAM controls: ce, we, word address, write data.
- Extracts and extends byte/halfword load results from the RAM read word and forwards the write-back triple to MEM/WB.
- The RAM has no byte enables, so SB/SH run as a two-cycle read-modify-write and stall the pipeline for one cycle.

Parameters:
- ADDR_W, 17, RAM word-address width; the RAM word address is mem_addr_i[ADDR_W+1:2].

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- aluop_i  in  8  operation code from EX/MEM
- mem_addr_i  in  32  byte address
- reg2_i  in  32  store data
- wd_i  in  5  destination register
- wreg_i  in  1  register write enable
- wdata_i  in  32  non-load result
- stall_i  in  1  MEM stage held by pipeline control
- flush_i  in  1  pipeline flush
- ram_data_i  in  32  RAM read word (combinational)
- ram_ce_o  out  1  RAM chip enable
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  ADDR_W  RAM word address
- ram_data_o  out  32  RAM write word
- wd_o  out  5  to MEM/WB
- wreg_o  out  1  to MEM/WB
- wdata_o  out  32  to MEM/WB
- stallreq_o  out  1  stall request to pipeline control
- misalign_o  out  1  address error on a load or store

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, merge_q=0.
  - All outputs are 0 while rst=0.
- Byte lanes are big-endian: addr[1:0]=00 selects bits 31:24, and 11 selects bits 7:0. Halfword addr[1]=0 selects bits 31:16.
- Non-memory op:
  - ram_ce_o=0, ram_we_o=0, ram_addr_o=0, ram_data_o=0.
  - wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i.
- Alignment:
  - LH/LHU/SH require addr[0]=0.
  - LW/SW require addr[1:0]=00.
  - On violation: misalign_o=1, ram_ce_o=0, ram_we_o=0, wreg_o=0. No state change.
- Loads LB/LBU/LH/LHU/LW, single cycle, no state change:
  - ram_ce_o=1, ram_we_o=0.
  - wdata_o is the selected lane of ram_data_i: sign-extended for LB/LH, zero-extended for LBU/LHU, the whole word for LW.
- SW, single cycle: ram_ce_o=1, ram_we_o=1, ram_data_o=reg2_i.
- SB/SH state machine, states IDLE, WRITE, HOLD:
  - IDLE:
    - ram_ce_o=1, ram_we_o=0, stallreq_o=1.
    - merge_q <= ram_data_i with the addressed lane replaced by reg2_i[7:0] (SB) or reg2_i[15:0] (SH).
    - Next state is WRITE.
  - WRITE:
    - ram_ce_o=1, ram_we_o=1, ram_data_o=merge_q, stallreq_o=0.
    - Next state is HOLD if stall_i=1, otherwise IDLE.
  - HOLD:
    - No RAM access, stallreq_o=0.
    - Prevents a repeated RMW on the still-held instruction.
    - Next state is IDLE when stall_i=0.
- Stores always drive wreg_o=0.
- flush_i=1:
  - Next state is IDLE.
  - In WRITE, ram_we_o is forced 0 in that same cycle (write cancelled).
  - In IDLE, stallreq_o is forced 0.
- Upstream inputs are held stable while stallreq_o=1 (guaranteed by pipeline control).
- Reset asserted mid-RMW: the pending write is lost; state returns to IDLE.

Decomposition:
- Shared defines, alongside the existing ones:
  - the eight load/store aluop encodings: LB 8'hE0, LBU 8'hE4, LH 8'hE1, LHU 8'hE5, LW 8'hE3, SB 8'hE8, SH 8'hE9, SW 8'hEB;
  - the state encodings;
  - ChipEnable/WriteEnable polarities.
- One sub-module, mem_lane_align: combinational lane select/extend for loads and lane merge for stores, shared by the load path and the RMW path.

Test Plan:
- Load extension:
  - Setup: RAM word 5 = 32'h8071_F2A4.
  - LB at addr 0x16 -> wdata_o=32'hFFFFFFF2.
  - LBU at addr 0x16 -> wdata_o=32'h000000F2.
  - LH at addr 0x14 -> wdata_o=32'hFFFF8071.
  - LW at addr 0x14 -> wdata_o=32'h8071F2A4.
- SB read-modify-write:
  - Setup: RAM word 2 = 32'h11223344.
  - Stimulus: SB addr 0x09, reg2=32'hAB.
  - Cycle 1: stallreq_o=1, ram_we_o=0.
  - Cycle 2: ram_we_o=1, ram_data_o=32'h11AB3344.
  - Afterwards: word 2 = 32'h11AB3344.
- SH with stall_i held 3 cycles after WRITE:
  - Exactly one write pulse.
  - HOLD for 3 cycles with ram_ce_o=0.
  - Then IDLE.
- Misaligned accesses:
  - LW addr 0x06 -> misalign_o=1, wreg_o=0, ram_ce_o=0.
  - SH addr 0x03 -> misalign_o=1, RAM unchanged.
- Cancelled RMW:
  - flush_i=1 in WRITE cycle of SB -> ram_we_o=0, RAM unchanged, next state IDLE.
  - rst pulsed low during WRITE -> outputs 0 immediately, state IDLE.
- SW addr 0x10, reg2=32'hDEADBEEF -> single cycle, ram_addr_o=4, ram_we_o=1, stallreq_o=0.
